// File: rtl/light_package.sv
// Shared light colors for the traffic light controller and its street-side
// environment, plus the safety-violation codes raised by the monitor.
package light_package;

  typedef enum logic [1:0] {green, yellow, red} colors;

  typedef enum logic [1:0] {NONE, CONFLICT, SKIP_YELLOW, BAD_SEQ} viol_t;

endpackage

// File: rtl/street_queue.sv
// One street's car queue: arrivals counted in, paced departures out while the
// light is green, and the traffic sensor decoded from the count.
module street_queue
  import light_package::*;
#(
  parameter int QDEPTH     = 15,
  parameter int DEPART_GAP = 2,
  parameter int QW         = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive,
  input  colors         light,
  output logic          t,
  output logic [QW-1:0] q,
  output logic          depart,
  output logic          drop
);

  localparam int GW = (DEPART_GAP > 1) ? $clog2(DEPART_GAP) : 1;
  localparam logic [QW-1:0] QFULL    = QW'(QDEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(DEPART_GAP - 1);

  logic [QW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          depart_q, depart_d;
  logic          drop_q, drop_d;
  logic          dep_ok;

  always_comb begin
    dep_ok   = (light == green) && (cnt_q != '0) && (gap_q == '0);
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    depart_d = dep_ok;
    drop_d   = 1'b0;

    // A simultaneous arrival and departure cancel, so a full queue never drops then.
    if (arrive && !dep_ok) begin
      if (cnt_q == QFULL) drop_d = 1'b1;
      else                cnt_d  = cnt_q + 1'b1;
    end else if (dep_ok && !arrive) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (dep_ok)                gap_d = GAP_LOAD;
    else if (light != green)   gap_d = '0;
    else if (gap_q != '0)      gap_d = gap_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      gap_q    <= '0;
      depart_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      depart_q <= depart_d;
      drop_q   <= drop_d;
    end
  end

  assign t      = (cnt_q != '0);
  assign q      = cnt_q;
  assign depart = depart_q;
  assign drop   = drop_q;

endmodule

// File: rtl/tlc_street_env.sv
// Street-side environment for the two-street light controller: two car queues
// feeding the Ta/Tb sensors and a sticky light-sequence safety monitor.
module tlc_street_env
  import light_package::*;
#(
  parameter int QDEPTH     = 15,
  parameter int DEPART_GAP = 2,
  parameter int QW         = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive_a,
  input  logic          arrive_b,
  input  colors         La,
  input  colors         Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          depart_a,
  output logic          depart_b,
  output logic          drop_a,
  output logic          drop_b,
  output logic          viol,
  output viol_t         viol_code
);

  street_queue #(.QDEPTH(QDEPTH), .DEPART_GAP(DEPART_GAP), .QW(QW)) u_queue_a (
    .clk    (clk),
    .reset  (reset),
    .arrive (arrive_a),
    .light  (La),
    .t      (Ta),
    .q      (qa),
    .depart (depart_a),
    .drop   (drop_a)
  );

  street_queue #(.QDEPTH(QDEPTH), .DEPART_GAP(DEPART_GAP), .QW(QW)) u_queue_b (
    .clk    (clk),
    .reset  (reset),
    .arrive (arrive_b),
    .light  (Lb),
    .t      (Tb),
    .q      (qb),
    .depart (depart_b),
    .drop   (drop_b)
  );

  colors last_a_q, last_a_d;
  colors last_b_q, last_b_d;
  logic  viol_q, viol_d;
  viol_t code_q, code_d;
  logic  conflict, skip_yellow, bad_seq;
  viol_t code_now;

  always_comb begin
    conflict    = (La != red) && (Lb != red);
    skip_yellow = ((last_a_q == green) && (La == red)) ||
                  ((last_b_q == green) && (Lb == red));
    bad_seq     = ((last_a_q == red)    && (La == yellow)) ||
                  ((last_a_q == yellow) && (La == green))  ||
                  ((last_b_q == red)    && (Lb == yellow)) ||
                  ((last_b_q == yellow) && (Lb == green));

    if (conflict)         code_now = CONFLICT;
    else if (skip_yellow) code_now = SKIP_YELLOW;
    else if (bad_seq)     code_now = BAD_SEQ;
    else                  code_now = NONE;

    last_a_d = La;
    last_b_d = Lb;
    viol_d   = viol_q;
    code_d   = code_q;
    // Only the first violation is recorded; the flag is sticky until reset.
    if (!viol_q && (code_now != NONE)) begin
      viol_d = 1'b1;
      code_d = code_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_a_q <= red;
      last_b_q <= red;
      viol_q   <= 1'b0;
      code_q   <= NONE;
    end else begin
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
      viol_q   <= viol_d;
      code_q   <= code_d;
    end
  end

  assign viol      = viol_q;
  assign viol_code = code_q;

endmodule
